pipelined_decode_stage: RTL and testbench

Parametrised decode stage for the pipelined MIPS core: register file, operand selection, branch/jump resolution, load-use hazard stall and the ID/EX pipeline register. It sits between fetch (IF/ID handshake) and execute (ID/EX handshake). It replaces the single-cycle decode path with registered outputs, a valid/ready flow and redirect signalling to fetch.

---
 rtl/decode_pkg.sv | 15 +
 rtl/decode_if.sv | 50 +++++
 rtl/decode_regfile.sv | 40 ++++
 rtl/pipelined_decode_stage.sv | 109 ++++++++++
 tb/tb_pipelined_decode_stage.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: branch condition encodings and
// default widths.
package decode_pkg;
  localparam int DATA_W_DEF    = 32;
  localparam int REG_COUNT_DEF = 32;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LEZ = 3'd2,
    BR_GTZ = 3'd3,
    BR_LTZ = 3'd4,
    BR_GEZ = 3'd5
  } br_op_t;
endpackage

// File: rtl/decode_if.sv
// Decode-stage bus: IF/ID handshake with controller fields, writeback port,
// redirect to fetch and the ID/EX handshake.
interface decode_if #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
);
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_instr;
  logic [DATA_W-1:0] if_pc;

  logic              ctl_shamt, ctl_alusrc, ctl_zero_ext, ctl_jump, ctl_jump_reg;
  logic              ctl_branch, ctl_mem_read, ctl_reg_write, ctl_link;
  logic [2:0]        ctl_branch_op;
  logic [RA_W-1:0]   ctl_dest;

  logic              wb_we;
  logic [RA_W-1:0]   wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              redirect_valid;
  logic [DATA_W-1:0] redirect_pc;

  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] ex_opa, ex_opb, ex_store;
  logic [RA_W-1:0]   ex_dest;
  logic              ex_reg_write, ex_mem_read, ex_link;
  logic [DATA_W-1:0] ex_link_pc;

  modport slave (
    input  if_valid, if_instr, if_pc,
    input  ctl_shamt, ctl_alusrc, ctl_zero_ext, ctl_jump, ctl_jump_reg,
    input  ctl_branch, ctl_mem_read, ctl_reg_write, ctl_link, ctl_branch_op, ctl_dest,
    input  wb_we, wb_addr, wb_data, ex_ready,
    output if_ready, redirect_valid, redirect_pc,
    output ex_valid, ex_opa, ex_opb, ex_store, ex_dest,
    output ex_reg_write, ex_mem_read, ex_link, ex_link_pc
  );

  modport master (
    output if_valid, if_instr, if_pc,
    output ctl_shamt, ctl_alusrc, ctl_zero_ext, ctl_jump, ctl_jump_reg,
    output ctl_branch, ctl_mem_read, ctl_reg_write, ctl_link, ctl_branch_op, ctl_dest,
    output wb_we, wb_addr, wb_data, ex_ready,
    input  if_ready, redirect_valid, redirect_pc,
    input  ex_valid, ex_opa, ex_opb, ex_store, ex_dest,
    input  ex_reg_write, ex_mem_read, ex_link, ex_link_pc
  );
endinterface

// File: rtl/decode_regfile.sv
// 2R1W register file, register 0 hardwired to zero.
// ID_WB_BYPASS_EN: same-cycle writeback data is forwarded to the read ports.
module decode_regfile #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(REG_COUNT)-1:0] ra_addr,
  output logic [DATA_W-1:0]            ra_data,
  input  logic [$clog2(REG_COUNT)-1:0] rb_addr,
  output logic [DATA_W-1:0]            rb_data,
  input  logic                         we,
  input  logic [$clog2(REG_COUNT)-1:0] waddr,
  input  logic [DATA_W-1:0]            wdata
);
  logic [REG_COUNT-1:0][DATA_W-1:0] mem_q, mem_d;
  logic                             wr_en;

  assign wr_en = we && (waddr != '0);

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  always_comb begin
    ra_data = (ra_addr == '0) ? '0 : mem_q[ra_addr];
    rb_data = (rb_addr == '0) ? '0 : mem_q[rb_addr];
`ifdef ID_WB_BYPASS_EN
    if (wr_en && waddr == ra_addr) ra_data = wdata;
    if (wr_en && waddr == rb_addr) rb_data = wdata;
`endif
  end
endmodule

// File: rtl/pipelined_decode_stage.sv
// MIPS decode stage: operand select, branch/jump resolution, load-use stall
// and ID/EX register. Optional ID_WB_BYPASS_EN enables writeback forwarding.
module pipelined_decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_COUNT = REG_COUNT_DEF
) (
  input  logic    clk,
  input  logic    rst,
  decode_if.slave bus
);
  localparam int RA_W = $clog2(REG_COUNT);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] store;
    logic [RA_W-1:0]   dest;
    logic              reg_write;
    logic              mem_read;
    logic              link;
    logic [DATA_W-1:0] link_pc;
  } idex_t;

  idex_t             idex_q, idex_d;
  logic [RA_W-1:0]   rs, rt;
  logic [DATA_W-1:0] rs_data, rt_data, simm, imm, btgt, jtgt;
  logic              hazard, advance, if_ready, accept, br_cond, take;
  logic              unused_instr;

  assign rs = bus.if_instr[21 +: RA_W];
  assign rt = bus.if_instr[16 +: RA_W];
  assign unused_instr = ^bus.if_instr[31:26];

  decode_regfile #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (rs),
    .ra_data (rs_data),
    .rb_addr (rt),
    .rb_data (rt_data),
    .we      (bus.wb_we),
    .waddr   (bus.wb_addr),
    .wdata   (bus.wb_data)
  );

  always_comb begin
    simm = {{(DATA_W-16){bus.if_instr[15]}}, bus.if_instr[15:0]};
    imm  = bus.ctl_zero_ext ? {{(DATA_W-16){1'b0}}, bus.if_instr[15:0]} : simm;
    btgt = bus.if_pc + (simm << 2);
    jtgt = {bus.if_pc[DATA_W-1:28], bus.if_instr[25:0], 2'b00};

    // Sign/zero tests cover all single-operand conditions without a signed compare.
    case (bus.ctl_branch_op)
      BR_EQ:   br_cond = (rs_data == rt_data);
      BR_NE:   br_cond = (rs_data != rt_data);
      BR_LEZ:  br_cond = rs_data[DATA_W-1] || (rs_data == '0);
      BR_GTZ:  br_cond = !rs_data[DATA_W-1] && (rs_data != '0);
      BR_LTZ:  br_cond = rs_data[DATA_W-1];
      BR_GEZ:  br_cond = !rs_data[DATA_W-1];
      default: br_cond = 1'b0;
    endcase

    hazard  = idex_q.valid && idex_q.mem_read && (idex_q.dest != '0) &&
              ((idex_q.dest == rs) || (idex_q.dest == rt));
    advance = bus.ex_ready || !idex_q.valid;
    if_ready = !hazard && advance;
    accept  = bus.if_valid && if_ready;
    take    = bus.ctl_jump || bus.ctl_jump_reg || (bus.ctl_branch && br_cond);

    // Advancing without an accepted instruction loads a bubble.
    idex_d = idex_q;
    if (advance) begin
      idex_d = '0;
      if (accept) begin
        idex_d.valid     = 1'b1;
        idex_d.opa       = bus.ctl_shamt ? {{(DATA_W-5){1'b0}}, bus.if_instr[10:6]} : rs_data;
        idex_d.opb       = bus.ctl_alusrc ? imm : rt_data;
        idex_d.store     = rt_data;
        idex_d.dest      = bus.ctl_dest;
        idex_d.reg_write = bus.ctl_reg_write;
        idex_d.mem_read  = bus.ctl_mem_read;
        idex_d.link      = bus.ctl_link;
        idex_d.link_pc   = bus.if_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign bus.if_ready       = if_ready;
  assign bus.redirect_valid = accept && take;
  assign bus.redirect_pc    = bus.ctl_jump_reg ? rs_data : (bus.ctl_jump ? jtgt : btgt);

  assign bus.ex_valid     = idex_q.valid;
  assign bus.ex_opa       = idex_q.opa;
  assign bus.ex_opb       = idex_q.opb;
  assign bus.ex_store     = idex_q.store;
  assign bus.ex_dest      = idex_q.dest;
  assign bus.ex_reg_write = idex_q.reg_write;
  assign bus.ex_mem_read  = idex_q.mem_read;
  assign bus.ex_link      = idex_q.link;
  assign bus.ex_link_pc   = idex_q.link_pc;
endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Scoreboarded bench for pipelined_decode_stage: expected ID/EX packets are
// queued at accept and compared as they leave ID/EX.
module tb_pipelined_decode_stage;
  import decode_pkg::*;

  localparam int DW  = 32;
  localparam int RAW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_if #(.DATA_W(DW), .RA_W(RAW)) bus ();

  pipelined_decode_stage #(.DATA_W(DW), .REG_COUNT(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit         shamt, alusrc, zext, jump, jr, branch, mr, rw, link;
    logic [2:0] bop;
    logic [4:0] dest;
  } ctl_t;

  typedef struct packed {
    logic [31:0] opa, opb, store;
    logic [4:0]  dest;
    logic        rw, mr, lk;
    logic [31:0] lpc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rf[32];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic ctl_t c0();
    ctl_t c;
    c = '{default: 0};
    return c;
  endfunction

  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc, input ctl_t c);
    exp_t        e;
    logic [31:0] rsd, rtd, imm;
    rsd   = rf[instr[25:21]];
    rtd   = rf[instr[20:16]];
    imm   = c.zext ? {16'h0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    e.opa = c.shamt ? {27'h0, instr[10:6]} : rsd;
    e.opb = c.alusrc ? imm : rtd;
    e.store = rtd;
    e.dest  = c.dest;
    e.rw    = c.rw;
    e.mr    = c.mr;
    e.lk    = c.link;
    e.lpc   = pc;
    return e;
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input ctl_t c);
    bus.if_instr      = instr;
    bus.if_pc         = pc;
    bus.ctl_shamt     = c.shamt;
    bus.ctl_alusrc    = c.alusrc;
    bus.ctl_zero_ext  = c.zext;
    bus.ctl_jump      = c.jump;
    bus.ctl_jump_reg  = c.jr;
    bus.ctl_branch    = c.branch;
    bus.ctl_mem_read  = c.mr;
    bus.ctl_reg_write = c.rw;
    bus.ctl_link      = c.link;
    bus.ctl_branch_op = c.bop;
    bus.ctl_dest      = c.dest;
  endtask

  // Presents an instruction for one cycle; returns at the following negedge.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input ctl_t c, output bit acc);
    @(posedge clk); #1;
    drive(instr, pc, c);
    bus.if_valid = 1'b1;
    @(negedge clk);
    acc = bus.if_ready;
    if (acc) sb.push_back(model(instr, pc, c));
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.if_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.if_valid = 1'b0;
    bus.wb_we    = 1'b1;
    bus.wb_addr  = a;
    bus.wb_data  = d;
    @(posedge clk); #1;
    bus.wb_we = 1'b0;
    if (a != 5'd0) rf[a] = d;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.ex_valid && bus.ex_ready) begin
      exp_t e, g;
      n_checks++;
      g = {bus.ex_opa, bus.ex_opb, bus.ex_store, bus.ex_dest, bus.ex_reg_write,
           bus.ex_mem_read, bus.ex_link, bus.ex_link_pc};
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got packet %h, expected none", g);
      end else begin
        e = sb.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL sb_packet: got %h, expected %h", g, e);
        end
      end
    end
  end

  task automatic test_reset();
    bit ok;
    #12;
    n_checks++;
    ok = (bus.ex_valid === 1'b0) && (bus.if_ready === 1'b1) && (bus.redirect_valid === 1'b0);
    if (!ok) begin
      n_fail++;
      $display("FAIL reset_ctl: ex_valid=%b if_ready=%b redirect=%b, expected 0 1 0",
               bus.ex_valid, bus.if_ready, bus.redirect_valid);
    end
    n_checks++;
    if ({bus.ex_opa, bus.ex_opb, bus.ex_store, bus.ex_dest, bus.ex_reg_write, bus.ex_mem_read,
         bus.ex_link, bus.ex_link_pc} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: opa=%h opb=%h store=%h lpc=%h, expected all 0",
               bus.ex_opa, bus.ex_opb, bus.ex_store, bus.ex_link_pc);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_operands();
    ctl_t c;
    bit   acc;
    write_reg(5'd1, 32'd5);
    write_reg(5'd2, 32'd5);
    c = c0(); c.alusrc = 1; c.rw = 1; c.dest = 5'd2;
    issue({6'h08, 5'd1, 5'd2, 16'hFFFF}, 32'h4, c, acc);
    idle();
    n_checks++;
    if (!acc || bus.ex_opa !== 32'd5 || bus.ex_opb !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL addi_sext: acc=%b opa=%h opb=%h, expected 1 5 ffffffff", acc, bus.ex_opa, bus.ex_opb);
    end
    c.zext = 1;
    issue({6'h0c, 5'd1, 5'd2, 16'hFFFF}, 32'h8, c, acc);
    idle();
    n_checks++;
    if (bus.ex_opb !== 32'h0000_FFFF) begin
      n_fail++;
      $display("FAIL addi_zext: opb=%h, expected 0000ffff", bus.ex_opb);
    end
    c = c0(); c.shamt = 1; c.rw = 1; c.dest = 5'd4;
    issue({6'h0, 5'd0, 5'd2, 5'd4, 5'd7, 6'h0}, 32'hC, c, acc);
    idle();
    n_checks++;
    if (bus.ex_opa !== 32'd7 || bus.ex_opb !== 32'd5) begin
      n_fail++;
      $display("FAIL shamt: opa=%h opb=%h, expected 7 5", bus.ex_opa, bus.ex_opb);
    end
  endtask

  task automatic test_branch();
    ctl_t        c;
    bit          acc;
    logic [4:0]  rs_t[6] = '{5'd5, 5'd5, 5'd1, 5'd0, 5'd0, 5'd5};
    logic [2:0]  op_t[6] = '{BR_LTZ, BR_GEZ, BR_GTZ, BR_LEZ, BR_GTZ, BR_LEZ};
    bit          tk_t[6] = '{1, 0, 1, 1, 0, 1};
    c = c0(); c.branch = 1; c.bop = BR_EQ;
    issue({6'h04, 5'd1, 5'd2, 16'd4}, 32'h100, c, acc);
    n_checks++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h110) begin
      n_fail++;
      $display("FAIL beq_taken: redirect=%b pc=%h, expected 1 00000110", bus.redirect_valid, bus.redirect_pc);
    end
    idle();
    n_checks++;
    if (bus.redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_idle: redirect=%b, expected 0", bus.redirect_valid);
    end
    write_reg(5'd2, 32'd6);
    issue({6'h04, 5'd1, 5'd2, 16'd4}, 32'h100, c, acc);
    n_checks++;
    if (bus.redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL beq_not_taken: redirect=%b, expected 0", bus.redirect_valid);
    end
    c.bop = BR_NE;
    issue({6'h05, 5'd1, 5'd2, 16'hFFFE}, 32'h100, c, acc);
    n_checks++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'hF8) begin
      n_fail++;
      $display("FAIL bne_back: redirect=%b pc=%h, expected 1 000000f8", bus.redirect_valid, bus.redirect_pc);
    end
    write_reg(5'd5, 32'h8000_0000);
    for (int i = 0; i < 6; i++) begin
      c.bop = op_t[i];
      issue({6'h01, rs_t[i], 5'd0, 16'd8}, 32'h200, c, acc);
      n_checks++;
      if (bus.redirect_valid !== tk_t[i]) begin
        n_fail++;
        $display("FAIL br_sign[%0d]: redirect=%b, expected %b", i, bus.redirect_valid, tk_t[i]);
      end
    end
    idle();
  endtask

  task automatic test_jump();
    ctl_t c;
    bit   acc;
    c = c0(); c.jump = 1; c.link = 1; c.rw = 1; c.dest = 5'd31;
    issue({6'h03, 26'h40}, 32'h1000_0004, c, acc);
    n_checks++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h1000_0100) begin
      n_fail++;
      $display("FAIL jump: redirect=%b pc=%h, expected 1 10000100", bus.redirect_valid, bus.redirect_pc);
    end
    c = c0(); c.jump = 1; c.branch = 1; c.bop = BR_NE;
    issue({6'h04, 5'd1, 5'd2, 16'h0010}, 32'h2000_0000, c, acc);
    n_checks++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h2088_0040) begin
      n_fail++;
      $display("FAIL jump_over_branch: redirect=%b pc=%h, expected 1 20880040", bus.redirect_valid, bus.redirect_pc);
    end
    write_reg(5'd31, 32'h2000);
    c = c0(); c.jr = 1;
    issue({6'h0, 5'd31, 15'h0, 6'h08}, 32'h300, c, acc);
    n_checks++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h2000) begin
      n_fail++;
      $display("FAIL jr: redirect=%b pc=%h, expected 1 00002000", bus.redirect_valid, bus.redirect_pc);
    end
    idle();
  endtask

  task automatic test_load_use();
    ctl_t c, cl;
    bit   acc;
    int   stalls;
    cl = c0(); cl.alusrc = 1; cl.mr = 1; cl.rw = 1; cl.dest = 5'd3;
    issue({6'h23, 5'd1, 5'd3, 16'h0}, 32'h400, cl, acc);
    c = c0(); c.rw = 1; c.dest = 5'd4;
    stalls = 0;
    acc = 0;
    for (int i = 0; i < 6 && !acc; i++) begin
      issue({6'h0, 5'd3, 5'd1, 5'd4, 5'd0, 6'h20}, 32'h404, c, acc);
      if (!acc) stalls++;
      else begin
        n_checks++;
        if (bus.ex_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL load_use_bubble: ex_valid=%b, expected 0", bus.ex_valid);
        end
      end
    end
    n_checks++;
    if (!acc || stalls != 1) begin
      n_fail++;
      $display("FAIL load_use_stall: accepted=%b stalls=%0d, expected 1 1", acc, stalls);
    end
    cl.dest = 5'd0;
    issue({6'h23, 5'd1, 5'd0, 16'h0}, 32'h500, cl, acc);
    issue({6'h0, 5'd0, 5'd0, 5'd4, 5'd0, 6'h20}, 32'h504, c, acc);
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL r0_no_stall: if_ready=%b, expected 1", acc);
    end
    idle();
  endtask

  task automatic test_bypass();
    ctl_t c;
    exp_t e;
    bit   acc;
    write_reg(5'd4, 32'h11);
    c = c0(); c.rw = 1; c.dest = 5'd6;
    @(posedge clk); #1;
    drive({6'h0, 5'd4, 5'd0, 5'd6, 5'd0, 6'h20}, 32'h600, c);
    bus.if_valid = 1'b1;
    bus.wb_we = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'hAA;
    @(negedge clk);
    e = model({6'h0, 5'd4, 5'd0, 5'd6, 5'd0, 6'h20}, 32'h600, c);
`ifdef ID_WB_BYPASS_EN
    e.opa = 32'hAA;
`endif
    if (bus.if_ready) sb.push_back(e);
    @(posedge clk); #1;
    bus.wb_we = 1'b0; bus.if_valid = 1'b0;
    rf[4] = 32'hAA;
    @(negedge clk);
    n_checks++;
    if (bus.ex_opa !== e.opa) begin
      n_fail++;
      $display("FAIL wb_same_cycle: opa=%h, expected %h", bus.ex_opa, e.opa);
    end
    issue({6'h0, 5'd4, 5'd0, 5'd6, 5'd0, 6'h20}, 32'h604, c, acc);
    idle();
    n_checks++;
    if (bus.ex_opa !== 32'hAA) begin
      n_fail++;
      $display("FAIL wb_after: opa=%h, expected 000000aa", bus.ex_opa);
    end
    write_reg(5'd0, 32'hDEAD);
    issue({6'h0, 5'd0, 5'd0, 5'd6, 5'd0, 6'h20}, 32'h608, c, acc);
    idle();
    n_checks++;
    if (bus.ex_opa !== 32'h0 || bus.ex_store !== 32'h0) begin
      n_fail++;
      $display("FAIL r0_write: opa=%h store=%h, expected 0 0", bus.ex_opa, bus.ex_store);
    end
  endtask

  task automatic test_backpressure();
    ctl_t c;
    bit   acc, ok;
    c = c0(); c.rw = 1; c.dest = 5'd7;
    issue({6'h0, 5'd1, 5'd2, 5'd7, 5'd0, 6'h20}, 32'h700, c, acc);
    @(posedge clk); #1;
    bus.ex_ready = 1'b0;
    c.dest = 5'd8;
    drive({6'h0, 5'd1, 5'd2, 5'd8, 5'd0, 6'h20}, 32'h704, c);
    bus.if_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      ok = bus.if_ready === 1'b0 && bus.ex_valid === 1'b1 && bus.ex_opa === 32'd5 &&
           bus.ex_opb === 32'd6 && bus.ex_dest === 5'd7 && bus.ex_link_pc === 32'h700;
      if (!ok) begin
        n_fail++;
        $display("FAIL hold[%0d]: if_ready=%b ex_valid=%b opa=%h opb=%h dest=%0d, expected 0 1 5 6 7",
                 k, bus.if_ready, bus.ex_valid, bus.ex_opa, bus.ex_opb, bus.ex_dest);
      end
      if (k < 2) @(posedge clk);
    end
    #1;
    bus.if_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_opa !== 32'h0 || bus.if_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_hold: ex_valid=%b opa=%h if_ready=%b, expected 0 0 1",
               bus.ex_valid, bus.ex_opa, bus.if_ready);
    end
    #2;
    rst = 1'b0;
    bus.ex_ready = 1'b1;
    sb.delete();
    write_reg(5'd1, 32'd9);
    c = c0(); c.rw = 1; c.dest = 5'd9;
    issue({6'h0, 5'd1, 5'd0, 5'd9, 5'd0, 6'h20}, 32'h800, c, acc);
    idle();
    n_checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_opa !== 32'd9) begin
      n_fail++;
      $display("FAIL after_reset: ex_valid=%b opa=%h, expected 1 9", bus.ex_valid, bus.ex_opa);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    bus.if_valid = 1'b0;
    bus.ex_ready = 1'b1;
    bus.wb_we    = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
    drive(32'h0, 32'h0, c0());
    test_reset();
    test_operands();
    test_branch();
    test_jump();
    test_load_use();
    test_bypass();
    test_backpressure();
    idle();
    idle();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d packets outstanding, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
